// File: rtl/l0_pool_reader.sv
// l0_pool_reader: 2x2 signed max-pool over the layer-0 feature-map RAM.
// Optional ReLU clamp on each result: define L0_POOL_RELU_EN.
module l0_pool_reader #(
  parameter int W  = 26,
  parameter int H  = 26,
  parameter int DW = 18,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic [AW-1:0] addr_rd,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          done
);

  localparam int NC = W / 2;
  localparam int NR = H / 2;
  localparam int CW = (NC > 1) ? $clog2(NC) : 1;
  localparam int RW = (NR > 1) ? $clog2(NR) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    OUT,
    DONE
  } state_t;

  state_t state_q, state_d;
  logic [2:0] ph_q, ph_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [AW-1:0] addr_q, addr_d;
  logic signed [DW-1:0] acc_q, acc_d;
  logic signed [DW-1:0] data_q, data_d;
  logic busy_q, busy_d;
  logic valid_q, valid_d;
  logic last_q, last_d;
  logic done_q, done_d;

  logic signed [DW-1:0] smp, mx, res;
  logic [AW-1:0] base;
  logic is_last;

  function automatic logic [AW-1:0] base_of(
    input logic [RW-1:0] r,
    input logic [CW-1:0] c
  );
    return AW'(2 * int'(r) * W + 2 * int'(c));
  endfunction

  assign busy      = busy_q;
  assign addr_rd   = addr_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign done      = done_q;

  // Window sequencing, running max and result handshake.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    row_d   = row_q;
    col_d   = col_q;
    addr_d  = addr_q;
    acc_d   = acc_q;
    data_d  = data_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;

    base    = base_of(row_q, col_q);
    is_last = (row_q == RW'(NR - 1)) &&
              (col_q == CW'(NC - 1));
    smp     = $signed(rd_data);
    if (ph_q == 3'd1) mx = smp;
    else mx = (smp > acc_q) ? smp : acc_q;
`ifdef L0_POOL_RELU_EN
    res = mx[DW-1] ? '0 : mx;
`else
    res = mx;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD;
          ph_d    = 3'd0;
          busy_d  = 1'b1;
          addr_d  = base;
        end
      end
      RD: begin
        if (ph_q != 3'd0) acc_d = mx;
        case (ph_q)
          3'd0: addr_d = base + AW'(1);
          3'd1: addr_d = base + AW'(W);
          3'd2: addr_d = base + AW'(W + 1);
          default: ;
        endcase
        if (ph_q == 3'd4) begin
          data_d  = res;
          valid_d = 1'b1;
          last_d  = is_last;
          state_d = OUT;
        end else begin
          ph_d = ph_q + 3'd1;
        end
      end
      OUT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            if (col_q == CW'(NC - 1)) begin
              col_d = '0;
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
            addr_d  = base_of(row_d, col_d);
            ph_d    = 3'd0;
            state_d = RD;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        row_d   = '0;
        col_d   = '0;
        addr_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ph_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      row_q   <= row_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_l0_pool_reader.sv
// tb_l0_pool_reader: directed + random scans of l0_pool_reader
// against a window-max reference model of the RAM contents.
module tb_l0_pool_reader;
  localparam int W  = 26;
  localparam int H  = 26;
  localparam int DW = 18;
  localparam int AW = 10;
  localparam int N  = (W / 2) * (H / 2);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic [AW-1:0] addr_rd;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          done;

  logic [DW-1:0] ram [W*H];
  logic [DW-1:0] got [N];
  int errors = 0;
  int checks = 0;

  l0_pool_reader #(.W(W), .H(H), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .addr_rd(addr_rd), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= ram[addr_rd];

  task automatic chk(input string tag, input logic [31:0] g,
                     input logic [31:0] e);
    checks++;
    assert (g === e) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, g, e);
    end
  endtask

  function automatic logic [DW-1:0] model(input int w);
    int b;
    int off [4];
    logic signed [DW-1:0] m, v;
    off = '{0, 1, W, W + 1};
    b = 2 * (w / (W / 2)) * W + 2 * (w % (W / 2));
    m = $signed(ram[b]);
    for (int k = 1; k < 4; k++) begin
      v = $signed(ram[b + off[k]]);
      if (v > m) m = v;
    end
`ifdef L0_POOL_RELU_EN
    if (m < 0) m = '0;
`endif
    return m;
  endfunction

  task automatic fill_ramp();
    for (int i = 0; i < W * H; i++) ram[i] = DW'(i);
  endtask

  // mode 0: ready=1, 1: random ready, 2: 10-cycle stall on window 0,
  // 3: start pokes at windows 5 and 168, 4: reset on window 50
  task automatic scan(input int mode);
    int idx, cyc, last_acc;
    bit fin;
    logic [AW-1:0] a0;
    idx = 0; cyc = 0; last_acc = 0; fin = 0;
    out_ready = (mode == 2) ? 1'b0 : 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (mode == 2) begin
      while (!out_valid && cyc < 10) begin
        @(posedge clk); #1; cyc++;
      end
      a0 = addr_rd;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1; cyc++;
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_data", 32'(out_data), 32'(model(0)));
        chk("stall_addr", 32'(addr_rd), 32'(a0));
      end
    end
    while (!fin && cyc < 4000) begin
      start = 1'b0;
      out_ready = (mode == 1) ? 1'($urandom % 2) : 1'b1;
      if (done) begin
        fin = 1;
        chk("count", idx, N);
        @(posedge clk); #1;
        chk("busy_after_done", 32'(busy), 0);
        chk("done_pulse", 32'(done), 0);
      end else if (out_valid) begin
        if (mode == 4 && idx == 50) begin
          rst_n = 1'b0;
          @(posedge clk); #1;
          rst_n = 1'b1;
          chk("rst_busy", 32'(busy), 0);
          chk("rst_valid", 32'(out_valid), 0);
          chk("rst_addr", 32'(addr_rd), 0);
          return;
        end
        if (mode == 3 && (idx == 5 || idx == N - 1)) start = 1'b1;
        if (out_ready) begin
          chk($sformatf("data_w%0d", idx), 32'(out_data),
              32'(model(idx)));
          chk($sformatf("last_w%0d", idx), 32'(out_last),
              32'(idx == N - 1));
          if (idx == 0 && mode != 2) chk("first_lat", 32'(cyc <= 6), 1);
          if (idx > 0 && (mode == 0 || mode == 3))
            chk("period", cyc - last_acc, 6);
          if (idx < N) got[idx] = out_data;
          last_acc = cyc;
          idx++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("finished", 32'(fin), 1);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    fill_ramp();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy0", 32'(busy), 0);
    chk("rst_addr0", 32'(addr_rd), 0);
    chk("rst_valid0", 32'(out_valid), 0);
    chk("rst_data0", 32'(out_data), 0);
    chk("rst_last0", 32'(out_last), 0);
    chk("rst_done0", 32'(done), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    scan(0);
    chk("ramp_w0", 32'(got[0]), 27);
    chk("ramp_w1", 32'(got[1]), 29);
    chk("ramp_w12", 32'(got[12]), 51);
    chk("ramp_w13", 32'(got[13]), 79);
    chk("ramp_w168", 32'(got[168]), 675);

    scan(2);
    chk("bp_w1", 32'(got[1]), 29);
    scan(3);
    scan(4);
    scan(0);
    chk("post_rst_w0", 32'(got[0]), 27);

    ram[0] = 18'h3FFFB; ram[1] = 18'h3FFFD;
    ram[W] = 18'h3FFF9; ram[W+1] = 18'h3FFFF;
    scan(0);
`ifdef L0_POOL_RELU_EN
    chk("neg_w0", 32'(got[0]), 0);
`else
    chk("neg_w0", 32'(got[0]), 32'h3FFFF);
`endif
    for (int p = 0; p < 4; p++) begin
      ram[0] = 18'h3FFFB; ram[1] = 18'h3FFFD;
      ram[W] = 18'h3FFF9; ram[W+1] = 18'h3FFFF;
      case (p)
        0: ram[0] = 18'd100;
        1: ram[1] = 18'd100;
        2: ram[W] = 18'd100;
        default: ram[W+1] = 18'd100;
      endcase
      scan(0);
      chk($sformatf("max_pos%0d", p), 32'(got[0]), 100);
    end

    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < W * H; i++) ram[i] = DW'($urandom);
      scan(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/l0_pool_reader.md
Name: l0_pool_reader

Overview:
- Read-side consumer of the layer-0 feature-map RAM: 26x26 map, 18-bit signed entries, row-major, 1-cycle registered read.
- Scans the map in non-overlapping 2x2 windows and drives the RAM read address for each window.
- Reduces each window to its signed maximum (2x2 max-pool) and streams the 13x13 = 169 pooled results downstream over a valid/ready handshake.
- Sits between the layer-0 RAM and the layer-1 input stage.

Parameters:
- W, 26, map width in pixels; must be even.
- H, 26, map height in pixels; must be even.
- DW, 18, data width (signed two's complement).
- AW, 10, RAM address width; W*H must be <= 2^AW.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle pulse; begins a full scan; ignored while busy=1.
- busy  output  1  high from the cycle after start is accepted until done.
- addr_rd  output  AW  RAM read address, registered.
- rd_data  input  DW  RAM read data; corresponds to addr_rd of the previous cycle.
- out_valid  output  1  pooled result available.
- out_ready  input  1  downstream accepts when out_valid & out_ready.
- out_data  output  DW  pooled result (signed).
- out_last  output  1  high with out_valid on the final window (index W/2*H/2-1).
- done  output  1  one-cycle pulse after the last result is accepted.

Behaviour:
- Reset (rst_n=0 at clock edge): state=IDLE; busy=0, addr_rd=0, out_valid=0, out_data=0, out_last=0, done=0; row/col counters=0.
- Reset is honoured mid-scan: all outputs above are forced the next cycle, and any partial window is discarded.
- Window (r,c), with r in 0..H/2-1 and c in 0..W/2-1, has base = 2r*W + 2c.
  - Read order: base, base+1, base+W, base+W+1.
  - Window order: c fastest, then r.
  - Arithmetic in AW bits; no wrap is possible for legal parameters.
- FSM:
  - IDLE: start=1 -> RD with k=0 and addr_rd=base. Otherwise stay in IDLE.
  - RD: one address issued per cycle for k=0..3.
    - Sample rd_data on the cycle after each address.
    - Sample 0 loads the accumulator; samples 1..3 update it with acc = max(acc, rd_data), signed compare.
    - After sample 3 is captured, load out_data, assert out_valid, set out_last if this is the final window -> OUT.
  - OUT: hold out_data, out_valid and out_last stable while out_ready=0; addr_rd does not advance.
    - On handshake (out_valid & out_ready), if not last: advance counters, set addr_rd to the next base -> RD. out_valid drops the cycle after the handshake.
    - If last: -> DONE.
  - DONE: pulse done=1 for one cycle, clear busy, reset counters and addr_rd to 0 -> IDLE.
- Latency: the first out_valid is asserted at cycle 6 after the start edge. Windows take 6 cycles each when out_ready is held high, and results are never dropped or duplicated.
- start while busy=1 is ignored with no side effect. start in the same cycle as done is ignored; a new start is accepted from IDLE only.
- Ties between equal values: the value is reported as-is (ordering is irrelevant to the result).
- addr_rd always stays within 0..W*H-1.

Optional Feature:
- Macro L0_POOL_RELU_EN.
- Defined: the result is clamped after max, so out_data = (acc < 0) ? 0 : acc. This adds no latency.
- Undefined: out_data = acc, raw signed max, negative values passed through.

Test Plan:
- Ramp map (ram[i]=i), out_ready=1, pulse start:
  - 169 results in order.
  - Windows 0, 1, 12 give 27, 29, 51; window 13 (r=1, c=0) gives 79.
  - Window 168 gives 675 with out_last=1.
  - done pulses once, then busy=0.
- Window 0 loaded with -5,-3,-7,-1 (0x3FFFB, 0x3FFFD, 0x3FFF9, 0x3FFFF):
  - Without L0_POOL_RELU_EN: out_data = 0x3FFFF.
  - With L0_POOL_RELU_EN: out_data = 0.
  - Repeat with the max placed in each of the 4 positions (value 100 at ram[0], ram[1], ram[26], ram[27] in turn) -> out_data = 100 each time.
- Backpressure: out_ready=0 for 10 cycles on window 0 with the ramp map:
  - out_valid stays 1, out_data stays 27, and addr_rd stays constant.
  - On release, window 1 = 29 follows, and the full 169-result sequence is still correct.
- start pulsed at windows 5 and 168 during a scan -> no restart; the output sequence is identical to the first scenario.
- rst_n=0 for one cycle while out_valid=1 on window 50:
  - Next cycle busy=0, out_valid=0, addr_rd=0.
  - A new start produces window 0 = 27 first and 169 results in total.
